skeeball_trigger_gen: RTL
=========================

// Module: skeeball_trigger_gen
// PURPOSE
//   Generates the single-cycle advance pulse consumed by the skeeball game
//   state machine (00 menu, 01 playing, 10 finish, 11 last score). Debounces
//   the start button and ball-return sensor, counts balls during play, and
//   times the finish and score screens. Reads the current state back so it
//   decides when the game advances.
// PARAMETERS
//   DEBOUNCE_CYCLES    1_000_000  stable cycles needed before a debounced level flips
//   BALLS_PER_GAME     9          balls per game; last ball ends play
//   FINISH_HOLD_CYCLES 150_000_000 cycles spent in finish (10) before advancing
//   SCORE_HOLD_CYCLES  250_000_000 cycles spent in last score (11) before advancing
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   reset       in   1  synchronous, active-high reset
//   state       in   2  current game state from the state machine
//   start_btn   in   1  raw asynchronous start button, active-high
//   ball_sensor in   1  raw asynchronous ball-return sensor, active-high
//   trigger     out  1  one-cycle advance pulse to the state machine
//   balls_left  out  $clog2(BALLS_PER_GAME+1)  balls remaining this game
//   hold_active out  1  high while the finish or score hold timer runs
// BEHAVIOUR
//   Reset (reset=1 at posedge): trigger=0, balls_left=BALLS_PER_GAME, hold_active=0;
//     sync flops, debounced levels, debounce counters, timers cleared; state_q<=state.
//   Input path: each raw input goes through 2-flop sync, then debounce.
//     - Debounced level flips only after the synced value differs from it for
//       DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts that count.
//     - Event = debounced 0->1, exactly one cycle. Release makes no event.
//     - Raw rise sampled at edge N, held steady -> event at N+2+DEBOUNCE_CYCLES.
//   trigger is registered: it is high the cycle after its cause.
//     - Max one pulse per cause. Never high two cycles running.
//     - After a pulse, no new pulse until state differs from state_q.
//       The state machine advances on the same edge that samples the pulse.
//   State entry: when state != state_q, clear ball count and hold timer, then state_q<=state.
//   Per state:
//     00 menu: start event -> trigger. Ball events ignored. balls_left=BALLS_PER_GAME.
//     01 playing: each ball event decrements balls_left.
//        Event taking balls_left to 0 -> trigger. Further ball events are ignored;
//        balls_left saturates at 0 and never wraps. Start events ignored.
//     10 finish: hold_active=1. Timer counts 0..FINISH_HOLD_CYCLES-1.
//        Terminal count -> trigger. Timer then stops. All events ignored.
//     11 score: hold_active=1. Timer counts to SCORE_HOLD_CYCLES-1, then trigger.
//        A start event also triggers early. Both in the same cycle -> one pulse only.
//   Ball and start events in the same cycle: only the one valid in the current state acts.
//   Reset mid-game: all counters clear. trigger=0 the cycle after reset.
//     The state machine has no reset; this block re-syncs from the state input.
//   Timer width $clog2(max hold); counters never exceed their terminal value.
// TESTING  (DEBOUNCE_CYCLES=4, BALLS_PER_GAME=3, FINISH_HOLD_CYCLES=10, SCORE_HOLD_CYCLES=20)
//   1. state=00, start_btn rises at edge 0 and holds -> trigger=1 only in cycle 7.
//   2. state=00, start_btn high 3 cycles then low -> no debounced event, trigger stays 0.
//   3. state=01, 3 clean ball pulses -> balls_left 3->2->1->0; pulse after 3rd only;
//      4th ball leaves balls_left=0, no pulse.
//   4. State machine in loop, state=10 entered -> trigger 10 cycles after entry,
//      single cycle; hold_active=1 throughout.
//   5. state=11, start event at cycle 5 -> early trigger; no second pulse at cycle 20.
//   6. Reset at cycle 2 of play with balls_left=1 -> balls_left=3, trigger=0, hold_active=0.

Source files
------------

// File: rtl/skeeball_trigger_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : skeeball_trigger_gen_if                              |
// | Description : Bundle between the skeeball game state machine side  |
// |               (master) and the trigger generator (slave).          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface skeeball_trigger_gen_if #(
    parameter int BALLS_PER_GAME = 9
);
    logic [1:0]                              state;
    logic                                    start_btn;
    logic                                    ball_sensor;
    logic                                    trigger;
    logic [$clog2(BALLS_PER_GAME+1)-1:0]     balls_left;
    logic                                    hold_active;

    modport master (
        output state, start_btn, ball_sensor,
        input  trigger, balls_left, hold_active
    );

    modport slave (
        input  state, start_btn, ball_sensor,
        output trigger, balls_left, hold_active
    );
endinterface
`default_nettype wire

// File: rtl/skeeball_trigger_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : skeeball_trigger_gen                                 |
// | Description : Debounces start button and ball sensor, counts balls |
// |               and times finish/score screens; emits a one-cycle    |
// |               advance pulse to the game state machine.             |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module skeeball_trigger_gen #(
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int BALLS_PER_GAME     = 9,
    parameter int FINISH_HOLD_CYCLES = 150_000_000,
    parameter int SCORE_HOLD_CYCLES  = 250_000_000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    skeeball_trigger_gen_if.slave bus
);
    typedef enum logic [1:0] {
        ST_MENU   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_FINISH = 2'b10,
        ST_SCORE  = 2'b11
    } game_state_t;

    localparam int c_BW       = $clog2(BALLS_PER_GAME + 1);
    localparam int c_DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_HOLD_MAX = (FINISH_HOLD_CYCLES > SCORE_HOLD_CYCLES) ?
                                FINISH_HOLD_CYCLES : SCORE_HOLD_CYCLES;
    localparam int c_TW       = (c_HOLD_MAX > 1) ? $clog2(c_HOLD_MAX) : 1;

    localparam logic [c_BW-1:0] c_BALLS    = c_BW'(BALLS_PER_GAME);
    localparam logic [c_BW-1:0] c_ONE_BALL = c_BW'(1);
    localparam logic [c_DW-1:0] c_DB_LAST  = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_FIN_LAST = c_TW'(FINISH_HOLD_CYCLES - 1);
    localparam logic [c_TW-1:0] c_SC_LAST  = c_TW'(SCORE_HOLD_CYCLES - 1);

    // Channel 0 = start button, channel 1 = ball sensor
    logic [1:0]      w_raw;
    logic [1:0]      w_evt;
    logic            w_start_evt;
    logic            w_ball_evt;
    logic            w_entry;
    logic            w_cause;

    game_state_t     r_state_q;
    logic            r_trig;
    logic            r_fired;
    logic            r_hold;
    logic [c_BW-1:0] r_balls;
    logic [c_TW-1:0] r_timer;

    assign w_raw       = {bus.ball_sensor, bus.start_btn};
    assign w_start_evt = w_evt[0];
    assign w_ball_evt  = w_evt[1];

    for (genvar g = 0; g < 2; g++) begin : g_debounce
        logic [1:0]      r_sync;
        logic            r_deb;
        logic            r_deb_d;
        logic            r_evt;
        logic [c_DW-1:0] r_cnt;

        // Two-flop synchroniser, then flip the debounced level only after
        // DEBOUNCE_CYCLES consecutive disagreeing samples; emit rising events
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync  <= 2'b00;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_evt   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync  <= {r_sync[0], w_raw[g]};
                r_deb_d <= r_deb;
                r_evt   <= r_deb & ~r_deb_d;
                if (r_sync[1] != r_deb) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_sync[1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_evt[g] = r_evt;
    end

    assign w_entry = (bus.state != r_state_q);

    // Decide whether the current (settled) state has a reason to advance
    always_comb begin
        w_cause = 1'b0;
        case (r_state_q)
            ST_MENU:   w_cause = w_start_evt;
            ST_PLAY:   w_cause = w_ball_evt && (r_balls == c_ONE_BALL);
            ST_FINISH: w_cause = (r_timer == c_FIN_LAST);
            ST_SCORE:  w_cause = (r_timer == c_SC_LAST) || w_start_evt;
            default:   w_cause = 1'b0;
        endcase
    end

    // Track the game state, run ball count / hold timer, and issue at most
    // one trigger per visit to a state (re-armed only by a state change)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= game_state_t'(bus.state);
            r_trig    <= 1'b0;
            r_fired   <= 1'b0;
            r_hold    <= 1'b0;
            r_balls   <= c_BALLS;
            r_timer   <= '0;
        end else begin
            r_hold <= bus.state[1];
            r_trig <= 1'b0;
            if (w_entry) begin
                r_state_q <= game_state_t'(bus.state);
                r_fired   <= 1'b0;
                r_balls   <= c_BALLS;
                r_timer   <= '0;
            end else begin
                case (r_state_q)
                    ST_MENU: r_balls <= c_BALLS;
                    ST_PLAY: begin
                        if (w_ball_evt && (r_balls != '0))
                            r_balls <= r_balls - c_ONE_BALL;
                    end
                    ST_FINISH: begin
                        if (r_timer != c_FIN_LAST)
                            r_timer <= r_timer + c_TW'(1);
                    end
                    ST_SCORE: begin
                        if (r_timer != c_SC_LAST)
                            r_timer <= r_timer + c_TW'(1);
                    end
                    default: r_balls <= r_balls;
                endcase
                if (w_cause && !r_fired && !r_trig) begin
                    r_trig  <= 1'b1;
                    r_fired <= 1'b1;
                end
            end
        end
    end

    assign bus.trigger     = r_trig;
    assign bus.balls_left  = r_balls;
    assign bus.hold_active = r_hold;

endmodule
`default_nettype wire
